// File: rtl/mem_dump_unit.sv
// mem_dump_unit: watches the CPU instruction stream for a run of all-zero
// instruction words and, once the run is long enough to call the CPU halted,
// walks data memory from word 0 to DEPTH-1. Each word is offered as one
// record on a valid/ready output port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   instr_rd   instruction word currently fetched by the CPU
//   dump_a     byte address to the data-memory read port ({index, 2'b00})
//   dump_rd    combinational read data for dump_a
//   out_valid  out_index/out_data hold a record (SEND state only)
//   out_ready  consumer accepts the record on a rising edge with out_valid
//   out_index  word index of the current record
//   out_data   memory word of the current record
//   halted     sticky flag: halt detected
//   done       sticky flag: all DEPTH records accepted
module mem_dump_unit #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned HALT_CONFIRM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_rd,
  output logic [31:0] dump_a,
  input  logic [31:0] dump_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_index,
  output logic [31:0] out_data,
  output logic        halted,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  localparam logic [7:0]  HaltCnt = 8'(HALT_CONFIRM);
  localparam logic [31:0] LastIdx = 32'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [31:0] index_q, index_d;
  logic [7:0]  halt_cnt_q, halt_cnt_d;
  logic [7:0]  halt_cnt_inc;
  logic [31:0] out_index_q, out_index_d;
  logic [31:0] out_data_q, out_data_d;
  logic        halted_q, halted_d;
  logic        done_q, done_d;

  // Saturating increment of the zero-instruction run length.
  assign halt_cnt_inc = (halt_cnt_q == HaltCnt) ? halt_cnt_q : halt_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    halt_cnt_d  = halt_cnt_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    halted_d    = halted_q;
    done_d      = done_q;

    unique case (state_q)
      StIdle: begin
        if (instr_rd == 32'd0) begin
          halt_cnt_d = halt_cnt_inc;
          if (halt_cnt_inc == HaltCnt) begin
            state_d  = StLoad;
            halted_d = 1'b1;
            index_d  = 32'd0;
          end
        end else begin
          halt_cnt_d = 8'd0;
        end
      end
      StLoad: begin
        // Capture the word so the record stays stable however long SEND lasts.
        out_data_d  = dump_rd;
        out_index_d = index_q;
        state_d     = StSend;
      end
      StSend: begin
        if (out_ready) begin
          if (index_q == LastIdx) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 32'd1;
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        // Terminal until reset.
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      index_q     <= 32'd0;
      halt_cnt_q  <= 8'd0;
      out_index_q <= 32'd0;
      out_data_q  <= 32'd0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      halt_cnt_q  <= halt_cnt_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      halted_q    <= halted_d;
      done_q      <= done_d;
    end
  end

  assign dump_a    = index_q << 2;
  assign out_valid = (state_q == StSend);
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign halted    = halted_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit. Three instances share clock and reset:
//   dut_a: DEPTH=4, HALT_CONFIRM=1 (main dump, backpressure, reset mid-dump)
//   dut_b: DEPTH=4, HALT_CONFIRM=3 (halt confirmation with interrupted run)
//   dut_c: DEPTH=1, HALT_CONFIRM=1 (single-record dump)
// Memory model: word k reads as 32'hA000_0000 + k.
module tb_mem_dump_unit;

  localparam logic [31:0] Nz   = 32'h0000_0013;
  localparam logic [31:0] Base = 32'hA000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] instr_a = Nz, instr_b = Nz, instr_c = Nz;
  logic        ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;
  logic [31:0] dump_a_a, dump_a_b, dump_a_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        valid_a, valid_b, valid_c;
  logic [31:0] idx_a, idx_b, idx_c;
  logic [31:0] data_a, data_b, data_c;
  logic        halted_a, halted_b, halted_c;
  logic        done_a, done_b, done_c;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] max_a_c = 32'd0;

  always #5 clk = ~clk;

  assign rd_a = Base + (dump_a_a >> 2);
  assign rd_b = Base + (dump_a_b >> 2);
  assign rd_c = Base + (dump_a_c >> 2);

  always @(negedge clk) if (dump_a_c > max_a_c) max_a_c = dump_a_c;

  mem_dump_unit #(.DEPTH(4), .HALT_CONFIRM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_rd(instr_a), .dump_a(dump_a_a), .dump_rd(rd_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_index(idx_a), .out_data(data_a),
    .halted(halted_a), .done(done_a)
  );

  mem_dump_unit #(.DEPTH(4), .HALT_CONFIRM(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_rd(instr_b), .dump_a(dump_a_b), .dump_rd(rd_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_index(idx_b), .out_data(data_b),
    .halted(halted_b), .done(done_b)
  );

  mem_dump_unit #(.DEPTH(1), .HALT_CONFIRM(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .instr_rd(instr_c), .dump_a(dump_a_c), .dump_rd(rd_c),
    .out_valid(valid_c), .out_ready(ready_c), .out_index(idx_c), .out_data(data_c),
    .halted(halted_c), .done(done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sit 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    chk({tag, "_index"}, idx_a, 32'd0);
    chk({tag, "_data"}, data_a, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted_a}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
    chk({tag, "_dump_a"}, dump_a_a, 32'd0);
  endtask

  initial begin
    // Reset state.
    #12;
    chk_a_zero("rst");
    chk("rst_c_halted", {31'd0, halted_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // HALT_CONFIRM=3 with a broken run: 0,0,nz,0,0 must not halt; next 0 does.
    for (int i = 0; i < 5; i++) begin
      instr_b = (i == 2) ? Nz : 32'd0;
      step();
      chk("b_no_halt", {31'd0, halted_b}, 32'd0);
      chk("b_no_valid", {31'd0, valid_b}, 32'd0);
    end
    instr_b = 32'd0;
    step();
    chk("b_halted", {31'd0, halted_b}, 32'd1);
    chk("b_valid_load", {31'd0, valid_b}, 32'd0);

    // Main dump, out_ready held high: records at 2-cycle spacing.
    chk("a_not_halted", {31'd0, halted_a}, 32'd0);
    instr_a = 32'd0;
    step();
    chk("a_halted", {31'd0, halted_a}, 32'd1);
    chk("a_load_valid", {31'd0, valid_a}, 32'd0);
    chk("a_load_addr", dump_a_a, 32'd0);
    ready_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("a_send_valid", {31'd0, valid_a}, 32'd1);
      chk("a_send_index", idx_a, 32'(k));
      chk("a_send_data", data_a, Base + 32'(k));
      chk("a_not_done", {31'd0, done_a}, 32'd0);
      step();
      chk("a_gap_valid", {31'd0, valid_a}, 32'd0);
      if (k < 3) chk("a_next_addr", dump_a_a, 32'((k + 1) * 4));
    end
    chk("a_done", {31'd0, done_a}, 32'd1);
    chk("a_last_addr", dump_a_a, 32'd12);

    // DONE is terminal: instructions and out_ready are ignored.
    for (int i = 0; i < 20; i++) begin
      instr_a = (i % 2 == 0) ? 32'd0 : Nz;
      step();
      chk("a_terminal", {29'd0, done_a, halted_a, valid_a}, 32'd6);
    end

    // DEPTH=1: a single record, then done.
    instr_c = 32'd0;
    ready_c = 1'b1;
    step();
    chk("c_halted", {31'd0, halted_c}, 32'd1);
    step();
    chk("c_valid", {31'd0, valid_c}, 32'd1);
    chk("c_index", idx_c, 32'd0);
    chk("c_data", data_c, Base);
    chk("c_not_done", {31'd0, done_c}, 32'd0);
    step();
    chk("c_done", {31'd0, done_c}, 32'd1);
    chk("c_valid_off", {31'd0, valid_c}, 32'd0);
    repeat (3) step();
    chk("c_done_hold", {30'd0, done_c, valid_c}, 32'd2);
    chk("c_dump_a_max", max_a_c, 32'd0);

    // Reset again, then dump with out_ready pattern 0,0,1 per record.
    #2 rst_n = 1'b0;
    #1 chk_a_zero("rst2");
    instr_a = 32'd0;
    ready_a = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk("bp_halted", {31'd0, halted_a}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_valid", {31'd0, valid_a}, 32'd1);
      chk("bp_index", idx_a, 32'(k));
      for (int h = 0; h < 2; h++) begin
        step();
        chk("bp_hold_valid", {31'd0, valid_a}, 32'd1);
        chk("bp_hold_index", idx_a, 32'(k));
        chk("bp_hold_data", data_a, Base + 32'(k));
      end
      ready_a = 1'b1;
      step();
      chk("bp_gap_valid", {31'd0, valid_a}, 32'd0);
      chk("bp_done", {31'd0, done_a}, (k == 3) ? 32'd1 : 32'd0);
      ready_a = 1'b0;
    end

    // Reset mid-dump while record 2 is in SEND abandons the dump.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    instr_a = 32'd0;
    ready_a = 1'b1;
    step();
    repeat (5) step();
    chk("mid_index", idx_a, 32'd2);
    chk("mid_valid", {31'd0, valid_a}, 32'd1);
    instr_a = Nz;
    #2 rst_n = 1'b0;
    #1 chk_a_zero("mid_rst");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_rst_quiet", {30'd0, halted_a, valid_a}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 Parameter DEPTH, default 1024, meaning number of 32-bit data-memory words to dump.
REQ-002 Parameter HALT_CONFIRM, default 1, meaning consecutive zero-instruction cycles required to declare halt (1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr_rd  input  32  instruction word currently fetched by the CPU.
REQ-006 dump_a  output  32  byte address to data-memory read port, always {index, 2'b00}.
REQ-007 dump_rd  input  32  combinational read data for dump_a.
REQ-008 out_valid  output  1  out_index/out_data hold a valid dump record.
REQ-009 out_ready  input  1  consumer accepts record when out_valid && out_ready at rising edge.
REQ-010 out_index  output  32  word index of current record.
REQ-011 out_data  output  32  memory word of current record.
REQ-012 halted  output  1  sticky: halt detected.
REQ-013 done  output  1  sticky: all DEPTH records accepted.

Function
REQ-014 States IDLE, LOAD, SEND, DONE; encoding free.
REQ-015 IDLE: halt counter increments (saturating at HALT_CONFIRM) each cycle instr_rd == 0, clears to 0 each cycle instr_rd != 0.
REQ-016 IDLE -> LOAD on the edge where counter reaches HALT_CONFIRM; same edge sets halted=1, index=0.
REQ-017 LOAD (one cycle): dump_a = index<<2; out_data <= dump_rd, out_index <= index at edge; -> SEND.
REQ-018 SEND: out_valid=1; out_index/out_data stable until accepted.
REQ-019 SEND with out_ready=0: remain in SEND, no output change.
REQ-020 SEND with out_ready=1 and index < DEPTH-1: index <= index+1, -> LOAD.
REQ-021 SEND with out_ready=1 and index == DEPTH-1: -> DONE, done=1; index does not wrap.
REQ-022 DONE: terminal until reset; out_valid=0; instr_rd ignored; no further records.
REQ-023 instr_rd ignored in LOAD, SEND, DONE; nonzero instruction after halt does not abort dump.
REQ-024 out_valid=0 in IDLE, LOAD, DONE; throughput at most one record per two cycles.
REQ-025 dump_a = index<<2 in all states (0 in IDLE); upper bits from 32-bit index, no truncation.
REQ-026 out_valid driven from state register only; never combinationally from out_ready.
REQ-027 Exactly DEPTH records, indices 0..DEPTH-1 in ascending order, each once.

Reset
REQ-028 rst_n low asynchronously forces IDLE, index=0, halt counter=0, out_valid=0, out_index=0, out_data=0, halted=0, done=0, dump_a=0.
REQ-029 Reset asserted mid-dump (LOAD or SEND) abandons dump; after release no record emitted until new halt detected.
REQ-030 Release of rst_n takes effect at first rising clk after deassertion; counting begins that edge.

Verification (DEPTH=4 unless stated; memory words k -> 32'hA000_0000+k)
REQ-031 HALT_CONFIRM=1, instr_rd nonzero 5 cycles then 0, out_ready=1 -> halted next edge; records (0,A0000000),(1,A0000001),(2,A0000002),(3,A0000003) at 2-cycle spacing; done=1 after 4th accept.
REQ-032 HALT_CONFIRM=3, instr_rd 0,0,nonzero,0,0,0 -> halted only after 6th cycle; no out_valid before.
REQ-033 out_ready toggled 0,0,1 per record -> each record held 3 cycles in SEND with out_data unchanged; order and count identical to REQ-031.
REQ-034 rst_n pulsed low while out_index=2 in SEND -> all outputs 0 immediately; after release with instr_rd nonzero, no out_valid for 20 cycles.
REQ-035 After done=1, drive instr_rd 0 and nonzero, out_ready=1 for 20 cycles -> done and halted stay 1, out_valid stays 0.
REQ-036 DEPTH=1 -> single record (0,A0000000), then done=1; dump_a never exceeds 0.
